// File: rtl/serial_add_pkg.sv
// Shared types and limits for the bit-serial adder controller.
package serial_add_pkg;

    localparam int SA_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit combinational full adder; the only arithmetic cell in the serial adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: LSB-first addition through one full-adder cell.
// Optional SERIAL_ADD_SUB_EN adds a 'sub' port selecting A-B instead of A+B+cin.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    generate
        if (WIDTH < 1 || WIDTH > SA_MAX_WIDTH) begin : g_bad_width
            $error("serial_add_ctrl: WIDTH out of range");
        end
    endgenerate

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, a_sh_next;
    logic [WIDTH-1:0] b_sh_reg, b_sh_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             carry_reg, carry_next;
    logic             cout_reg, cout_next;

    logic             fa_s, fa_co;
    logic [WIDTH-1:0] sum_shifted;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    full_adder_cell u_fa (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .cin  (carry_reg),
        .s    (fa_s),
        .cout (fa_co)
    );

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 lands at sum[0].
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_shifted = fa_s;
        end else begin : g_sum_wn
            assign sum_shifted = {fa_s, sum_reg[WIDTH-1:1]};
        end
    endgenerate

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction as A + ~B + 1; cout then reads as "no borrow".
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    always_comb begin
        state_next = state_reg;
        a_sh_next  = a_sh_reg;
        b_sh_next  = b_sh_reg;
        sum_next   = sum_reg;
        cnt_next   = cnt_reg;
        carry_next = carry_reg;
        cout_next  = cout_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    a_sh_next  = a;
                    b_sh_next  = b_load;
                    carry_next = carry_load;
                    cnt_next   = '0;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sum_next   = sum_shifted;
                carry_next = fa_co;
                a_sh_next  = a_sh_reg >> 1;
                b_sh_next  = b_sh_reg >> 1;
                cnt_next   = cnt_reg + 1'b1;
                if (cnt_reg == CW'(WIDTH - 1)) begin
                    cout_next  = fa_co;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            sum_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_sh_reg  <= a_sh_next;
            b_sh_reg  <= b_sh_next;
            sum_reg   <= sum_next;
            cnt_reg   <= cnt_next;
            carry_reg <= carry_next;
            cout_reg  <= cout_next;
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign busy      = (state_reg == ST_SHIFT);
    assign out_valid = (state_reg == ST_DONE);
    assign sum       = sum_reg;
    assign cout      = cout_reg;

endmodule
